// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared state type and sizing constants for the RAM burst reader
package ram_rd_pkg;
   localparam int RAM_DEPTH = 1024;
   localparam int LEN_W     = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;
endpackage

// File: rtl/rd_stream_fifo.sv
// rtl/rd_stream_fifo.sv - small synchronous FIFO whose head entry is held in a dedicated output register
module rd_stream_fifo
   import ram_rd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      dout_d   = dout_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // The head register follows the new read pointer; a write landing on an empty slot bypasses memory.
      if (push && ((count_q - CW'(pop)) == '0)) begin
         dout_d = din;
      end else if (count_d != '0) begin
         dout_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign count = count_q;
   assign empty = (count_q == '0);
endmodule

// File: rtl/ram_1024x8_burst_reader.sv
// rtl/ram_1024x8_burst_reader.sv - burst read master turning RAM reads into a backpressured byte stream
module ram_1024x8_burst_reader
   import ram_rd_pkg::*;
#(
   parameter int addr_int   = 10,
   parameter int data_width = 8,
   parameter int rd_lat     = 1,
   parameter int fifo_depth = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic [addr_int-1:0]   StartAddr,
   input  logic [LEN_W-1:0]      Len,
   output logic                  Busy,
   output logic                  Done,
   output logic [addr_int-1:0]   RA,
   output logic                  RClk_En,
   input  logic [data_width-1:0] RD,
   output logic [data_width-1:0] OutData,
   output logic                  OutValid,
   input  logic                  OutReady
);
   localparam int CW = $clog2(fifo_depth) + 1;

   rd_state_e           state_q, state_d;
   logic [addr_int-1:0] ra_q, ra_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [CW-1:0]       in_flight_q, in_flight_d;
   logic [rd_lat-1:0]   pipe_q, pipe_d;
   logic                done_q, done_d;
   logic [CW-1:0]       fifo_count;
   logic                fifo_empty;
   logic                push, pop, issue;
   logic [CW:0]         occupancy;

   assign push = pipe_q[rd_lat-1];
   assign pop  = ~fifo_empty & OutReady;
   // Reads still in the RAM pipe plus buffered bytes, net of the byte leaving this cycle.
   assign occupancy = (CW+1)'(in_flight_q) + (CW+1)'(fifo_count) - (CW+1)'(pop);
   assign issue     = (state_q == ISSUE) && (rem_q != '0) && (occupancy < (CW+1)'(fifo_depth));

   always_comb begin
      state_d     = state_q;
      ra_d        = ra_q;
      rem_d       = rem_q;
      done_d      = 1'b0;
      in_flight_d = in_flight_q + CW'(issue) - CW'(push);
      pipe_d      = (pipe_q << 1) | rd_lat'(issue);
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (Len != '0) begin
                  state_d = ISSUE;
                  ra_d    = StartAddr;
                  rem_d   = Len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (issue) begin
               ra_d  = ra_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (occupancy == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         ra_q        <= '0;
         rem_q       <= '0;
         in_flight_q <= '0;
         pipe_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ra_q        <= ra_d;
         rem_q       <= rem_d;
         in_flight_q <= in_flight_d;
         pipe_q      <= pipe_d;
         done_q      <= done_d;
      end
   end

   rd_stream_fifo #(
      .DEPTH (fifo_depth),
      .WIDTH (data_width)
   ) u_fifo (
      .clk   (Clk),
      .rst   (Rst),
      .push  (push),
      .pop   (pop),
      .din   (RD),
      .dout  (OutData),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign Busy     = (state_q != IDLE);
   assign Done     = done_q;
   assign RA       = ra_q;
   assign RClk_En  = issue;
   assign OutValid = ~fifo_empty;
endmodule

// File: tb/tb_ram_1024x8_burst_reader.sv
// tb/tb_ram_1024x8_burst_reader.sv - scoreboard bench for the RAM burst reader at read latency 1 and 2
module tb_ram_1024x8_burst_reader;
   localparam int NI = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [9:0]            start_addr;
   logic [10:0]           len;
   logic                  out_ready;
   logic [NI-1:0]         busy, done, rclk_en, out_valid;
   logic [NI-1:0][9:0]    ra;
   logic [NI-1:0][7:0]    rd, out_data;
   logic [7:0]            mem [1024];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int         rx_cnt [NI], iss_cnt [NI], done_cnt [NI];
   int         start_cyc [NI], first_cyc [NI], last_cyc [NI], done_cyc [NI];
   int         m_base [NI], m_len [NI];
   logic [7:0] first_byte [NI], last_byte [NI], stall_data [NI];
   bit         stall [NI];

   typedef struct {
      int addr;
      int n;
      int mode;
      int first;
      int last;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [7:0] r1, r2;

      ram_1024x8_burst_reader #(.rd_lat(g + 1)) u_dut (
         .Clk       (clk),
         .Rst       (rst),
         .Start     (start),
         .StartAddr (start_addr),
         .Len       (len),
         .Busy      (busy[g]),
         .Done      (done[g]),
         .RA        (ra[g]),
         .RClk_En   (rclk_en[g]),
         .RD        (rd[g]),
         .OutData   (out_data[g]),
         .OutValid  (out_valid[g]),
         .OutReady  (out_ready)
      );

      always @(posedge clk) begin
         if (rclk_en[g]) r1 <= mem[ra[g]];
         r2 <= r1;
      end
      assign rd[g] = (g == 0) ? r1 : r2;
   end

   task automatic check(input bit ok, input string name, input int inst, input int act, input int want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s (rd_lat=%0d): got %0d, expected %0d", name, inst + 1, act, want);
      end
   endtask

   // Reference model: a burst from address A of N bytes is the byte stream mem[(A+i) mod 1024], i = 0..N-1.
   always @(negedge clk) begin
      int want;
      if (rst) begin
         for (int g = 0; g < NI; g++) stall[g] = 1'b0;
      end else begin
         for (int g = 0; g < NI; g++) begin
            if (stall[g]) begin
               check(out_valid[g] && (out_data[g] == stall_data[g]), "stall_hold", g, int'(out_data[g]), int'(stall_data[g]));
            end
            if (rclk_en[g]) begin
               want = (m_base[g] + iss_cnt[g]) % 1024;
               check(iss_cnt[g] < m_len[g], "extra_read", g, iss_cnt[g], m_len[g]);
               check(int'(ra[g]) == want, "ra_sequence", g, int'(ra[g]), want);
               check(iss_cnt[g] - rx_cnt[g] - int'(out_valid[g] & out_ready) < 4, "read_credit", g,
                     iss_cnt[g] - rx_cnt[g], 4);
               iss_cnt[g]++;
            end
            if (out_valid[g] && first_cyc[g] < 0) first_cyc[g] = cyc;
            if (out_valid[g] && out_ready) begin
               want = int'(mem[(m_base[g] + rx_cnt[g]) % 1024]);
               check(rx_cnt[g] < m_len[g] && int'(out_data[g]) == want, "stream_data", g, int'(out_data[g]), want);
               if (rx_cnt[g] == 0) first_byte[g] = out_data[g];
               last_byte[g] = out_data[g];
               last_cyc[g]  = cyc;
               rx_cnt[g]++;
            end
            if (done[g]) begin
               done_cnt[g]++;
               done_cyc[g] = cyc;
            end
            stall[g]      = out_valid[g] && !out_ready;
            stall_data[g] = out_data[g];
            if (start && !busy[g]) begin
               m_base[g]    = int'(start_addr);
               m_len[g]     = int'(len);
               start_cyc[g] = cyc + 1;
               first_cyc[g] = -1;
               rx_cnt[g]    = 0;
               iss_cnt[g]   = 0;
               done_cnt[g]  = 0;
            end
         end
      end
   end

   // mode: 0 ready held, 1 random ready, 2 twenty-cycle stall, 3 ready held plus a Start while busy
   task automatic run_burst(input int addr, input int n, input int mode);
      int t;
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = 10'(addr);
      len        = 11'(n);
      @(posedge clk); #1;
      start = 1'b0;
      for (t = 0; t < 6000; t++) begin
         case (mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !(t >= 10 && t < 30);
            default: out_ready = 1'b1;
         endcase
         if (mode == 3 && t == 4) begin
            start      = 1'b1;
            start_addr = 10'd0;
            len        = 11'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (mode == 2 && t == 29) begin
            for (int g = 0; g < NI; g++)
               check(iss_cnt[g] - rx_cnt[g] == 4, "stall_buffered", g, iss_cnt[g] - rx_cnt[g], 4);
         end
         if (busy == '0 && done_cnt[0] > 0 && done_cnt[1] > 0) break;
         @(posedge clk); #1;
      end
      check(t < 6000, "burst_timeout", 0, t, 6000);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_burst(input int n, input int mode, input int first, input int last);
      for (int g = 0; g < NI; g++) begin
         check(rx_cnt[g] == n, "byte_count", g, rx_cnt[g], n);
         check(iss_cnt[g] == n, "read_count", g, iss_cnt[g], n);
         check(done_cnt[g] == 1, "done_pulses", g, done_cnt[g], 1);
         check(busy[g] == 1'b0, "busy_after", g, int'(busy[g]), 0);
         if (n == 0) begin
            check(done_cyc[g] == start_cyc[g], "len0_done_cycle", g, done_cyc[g] - start_cyc[g], 0);
         end else begin
            check(first_cyc[g] - start_cyc[g] == g + 2, "first_latency", g, first_cyc[g] - start_cyc[g], g + 2);
            check(int'(first_byte[g]) == first, "first_byte", g, int'(first_byte[g]), first);
            check(int'(last_byte[g]) == last, "last_byte", g, int'(last_byte[g]), last);
            if (mode == 0 || mode == 3)
               check(last_cyc[g] - first_cyc[g] == n - 1, "throughput", g, last_cyc[g] - first_cyc[g], n - 1);
         end
      end
   endtask

   initial begin
      int t, addr, n;
      vecs[0] = '{0,    16,   0, 8'h00, 8'h0F};
      vecs[1] = '{1020, 8,    0, 8'hFC, 8'h03};
      vecs[2] = '{0,    1024, 1, 8'h00, 8'hFF};
      vecs[3] = '{100,  64,   2, 8'h64, 8'hA3};
      vecs[4] = '{1023, 2,    1, 8'hFF, 8'h00};
      vecs[5] = '{7,    1,    0, 8'h07, 8'h07};
      vecs[6] = '{200,  32,   3, 8'hC8, 8'hE7};
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

      rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++)
         check({busy[g], done[g], rclk_en[g], out_valid[g], ra[g], out_data[g]} == '0, "reset_state", g,
               int'({busy[g], done[g], rclk_en[g], out_valid[g], ra[g], out_data[g]}), 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_burst(vecs[i].addr, vecs[i].n, vecs[i].mode);
         check_burst(vecs[i].n, vecs[i].mode, vecs[i].first, vecs[i].last);
      end

      run_burst(5, 0, 0);
      check_burst(0, 0, 0, 0);

      // Abort a 64-byte burst once ten bytes have been accepted.
      @(posedge clk); #1;
      start = 1'b1; start_addr = 10'd300; len = 11'd64; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         if (rx_cnt[0] >= 10) break;
      end
      check(t < 200, "abort_wait_timeout", 0, t, 200);
      rst = 1'b1;
      #1;
      for (int g = 0; g < NI; g++)
         check({busy[g], done[g], rclk_en[g], out_valid[g], ra[g], out_data[g]} == '0, "abort_reset_state", g,
               int'({busy[g], done[g], rclk_en[g], out_valid[g], ra[g], out_data[g]}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         check(done_cnt[g] == 0, "abort_no_done", g, done_cnt[g], 0);
         check(out_valid[g] == 1'b0 && busy[g] == 1'b0, "abort_quiet", g, int'({busy[g], out_valid[g]}), 0);
      end
      run_burst(300, 64, 0);
      check_burst(64, 0, 300 % 256, 363 % 256);

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
         addr = int'($urandom_range(0, 1023));
         n    = int'($urandom_range(1, 80));
         run_burst(addr, n, 1);
         check_burst(n, 1, int'(mem[addr]), int'(mem[(addr + n - 1) % 1024]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
